// File: rtl/l1_evict_wb_pkg.sv
// Shared types and sizing for the L1 victim writeback buffer.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
`ifndef CORE_IDX_WIDTH
`define CORE_IDX_WIDTH 6
`endif

package l1_evict_wb_pkg;

    localparam int DEPTH      = 2;
    localparam int TAG_W      = 20;
    localparam int LINE_W     = 256;
    localparam int BEAT_W     = 32;
    localparam int ADDR_W     = 32;
    localparam int IDX_W      = `CORE_IDX_WIDTH;
    localparam int BEATS      = LINE_W / BEAT_W;
    localparam int BEAT_CNT_W = $clog2(BEATS);
    localparam int OFF_W      = $clog2(BEAT_W / 8);
    localparam int PTR_W      = $clog2(DEPTH);
    localparam int CNT_W      = $clog2(DEPTH + 1);
    localparam int RAW_W      = TAG_W + IDX_W + BEAT_CNT_W + OFF_W;

    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [IDX_W-1:0]  idx;
        logic [LINE_W-1:0] data;
    } victim_t;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    // Byte address of one beat: line address bits above the beat index, byte offset zero.
    function automatic logic [ADDR_W-1:0] beat_addr(
        input logic [TAG_W-1:0]      tag,
        input logic [IDX_W-1:0]      idx,
        input logic [BEAT_CNT_W-1:0] beat
    );
        logic [RAW_W-1:0] raw;
        raw = {tag, idx, beat, {OFF_W{1'b0}}};
        return ADDR_W'(raw);
    endfunction

endpackage

// File: rtl/l1_evict_fifo.sv
// Victim entry storage: circular FIFO with per-entry valid/tag/idx taps for lookup.
// Latency: push visible at head and on the taps the cycle after it is accepted.
// Backpressure: push ignored while full; pop ignored while empty.
module l1_evict_fifo
    import l1_evict_wb_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        push,
    input  victim_t                     din,
    input  logic                        pop,
    output logic                        full,
    output logic                        empty,
    output victim_t                     head,
    output logic [DEPTH-1:0]            ent_vld,
    output logic [DEPTH-1:0][TAG_W-1:0] ent_tag,
    output logic [DEPTH-1:0][IDX_W-1:0] ent_idx
);

    victim_t          mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign head    = mem[rd_ptr];

    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            ent_vld <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            count   <= count + CNT_W'(push_ok) - CNT_W'(pop_ok);
            ent_vld <= (ent_vld & ~(DEPTH'(pop_ok) << rd_ptr)) | (DEPTH'(push_ok) << wr_ptr);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= din;
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ent_tag[i] = mem[i].tag;
            ent_idx[i] = mem[i].idx;
        end
    end

endmodule

// File: rtl/l1_evict_wb.sv
// Dirty-victim writeback buffer: drains each buffered line as a BEATS-long write burst.
// Latency: burst starts two cycles after a push into an empty buffer; one idle cycle between bursts.
// Backpressure: wb_ack stalls the burst in place; ev_full tells upstream to stop pushing.
`ifndef CORE_IDX_WIDTH
`define CORE_IDX_WIDTH 6
`endif

module l1_evict_wb
    import l1_evict_wb_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       ev_push,
    input  logic                       ev_dirty,
    input  logic [TAG_W-1:0]           ev_tag,
    input  logic [`CORE_IDX_WIDTH-1:0] ev_idx,
    input  logic [LINE_W-1:0]          ev_data,
    output logic                       ev_full,
    input  logic [TAG_W-1:0]           lk_tag,
    input  logic [`CORE_IDX_WIDTH-1:0] lk_idx,
    output logic                       lk_hit,
    output logic                       wb_req,
    output logic [ADDR_W-1:0]          wb_addr,
    output logic [BEAT_W-1:0]          wb_data,
    output logic                       wb_last,
    input  logic                       wb_ack,
    output logic                       empty
);

    state_t                     state;
    state_t                     state_nxt;
    logic [BEAT_CNT_W-1:0]      beat_cnt;
    logic                       at_last;
    logic                       pop;
    logic                       fifo_empty;
    victim_t                    din;
    victim_t                    head;
    logic [DEPTH-1:0]           ent_vld;
    logic [DEPTH-1:0][TAG_W-1:0] ent_tag;
    logic [DEPTH-1:0][IDX_W-1:0] ent_idx;

    // Clean victims never enter the buffer.
    assign din = '{tag: ev_tag, idx: ev_idx, data: ev_data};

    l1_evict_fifo u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (ev_push & ev_dirty),
        .din     (din),
        .pop     (pop),
        .full    (ev_full),
        .empty   (fifo_empty),
        .head    (head),
        .ent_vld (ent_vld),
        .ent_tag (ent_tag),
        .ent_idx (ent_idx)
    );

    assign at_last = (beat_cnt == BEAT_CNT_W'(BEATS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            beat_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state == BURST && wb_ack) begin
                beat_cnt <= at_last ? '0 : beat_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        wb_req    = 1'b0;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) state_nxt = BURST;
            end
            BURST: begin
                wb_req = 1'b1;
                if (wb_ack && at_last) begin
                    pop       = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign wb_last = wb_req & at_last;
    assign wb_addr = wb_req ? beat_addr(head.tag, head.idx, beat_cnt) : '0;
    assign wb_data = wb_req ? head.data[beat_cnt*BEAT_W +: BEAT_W] : '0;
    assign empty   = fifo_empty & (state == IDLE);

    // The draining head stays valid until its pop registers, so refills keep stalling through the last ack.
    always_comb begin
        lk_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_vld[i] && ent_tag[i] == lk_tag && ent_idx[i] == lk_idx) lk_hit = 1'b1;
        end
    end

    a_no_push_when_full: assert property (@(posedge clk) disable iff (!rst_n) !(ev_push && ev_full));

endmodule

// File: tb/tb_l1_evict_wb.sv
// Randomized scoreboard bench for l1_evict_wb against a queue-level model of buffered lines and beats.
`ifndef CORE_IDX_WIDTH
`define CORE_IDX_WIDTH 6
`endif

module tb_l1_evict_wb;
    import l1_evict_wb_pkg::*;

    logic                       clk = 1'b0;
    logic                       rst_n = 1'b0;
    logic                       ev_push = 1'b0;
    logic                       ev_dirty = 1'b0;
    logic [TAG_W-1:0]           ev_tag = '0;
    logic [`CORE_IDX_WIDTH-1:0] ev_idx = '0;
    logic [LINE_W-1:0]          ev_data = '0;
    logic                       ev_full;
    logic [TAG_W-1:0]           lk_tag = '0;
    logic [`CORE_IDX_WIDTH-1:0] lk_idx = '0;
    logic                       lk_hit;
    logic                       wb_req;
    logic [ADDR_W-1:0]          wb_addr;
    logic [BEAT_W-1:0]          wb_data;
    logic                       wb_last;
    logic                       wb_ack = 1'b0;
    logic                       empty;

    always #5 clk = ~clk;

    l1_evict_wb dut (
        .clk(clk), .rst_n(rst_n),
        .ev_push(ev_push), .ev_dirty(ev_dirty), .ev_tag(ev_tag), .ev_idx(ev_idx),
        .ev_data(ev_data), .ev_full(ev_full),
        .lk_tag(lk_tag), .lk_idx(lk_idx), .lk_hit(lk_hit),
        .wb_req(wb_req), .wb_addr(wb_addr), .wb_data(wb_data), .wb_last(wb_last),
        .wb_ack(wb_ack), .empty(empty)
    );

    typedef struct {
        logic [TAG_W-1:0] tag;
        logic [IDX_W-1:0] idx;
    } line_t;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [BEAT_W-1:0] data;
        logic              last;
    } beat_t;

    line_t mq[$];
    beat_t bq[$];
    int    vectors = 0;
    int    miscompares = 0;
    int    cur_beat = 0;
    int    idle_run = 0;
    bit    gap_due = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: compares each cycle, then advances the model by what the coming edge will commit.
    always @(negedge clk) begin : mon
        logic  exp_hit;
        bit    full_before;
        beat_t b;
        line_t l;
        logic [63:0] line_addr;
        if (!rst_n) begin
            chk("rst_wb_req", wb_req, 0);
            chk("rst_ev_full", ev_full, 0);
            chk("rst_empty", empty, 1);
            chk("rst_lk_hit", lk_hit, 0);
            chk("rst_wb_last", wb_last, 0);
            chk("rst_wb_addr", wb_addr, 0);
            chk("rst_wb_data", wb_data, 0);
            mq.delete();
            bq.delete();
            cur_beat = 0;
            idle_run = 0;
            gap_due  = 1'b0;
        end else begin
            full_before = (mq.size() == DEPTH);
            chk("ev_full", ev_full, full_before);
            chk("empty", empty, mq.size() == 0);
            exp_hit = 1'b0;
            foreach (mq[i]) if (mq[i].tag == lk_tag && mq[i].idx == lk_idx) exp_hit = 1'b1;
            chk("lk_hit", lk_hit, exp_hit);
            if (gap_due) chk("gap_req", wb_req, 0);
            if (cur_beat != 0) chk("req_hold", wb_req, 1);
            gap_due = 1'b0;
            if (wb_req) begin
                idle_run = 0;
                if (bq.size() == 0) begin
                    chk("spurious_req", wb_req, 0);
                end else begin
                    chk("wb_addr", wb_addr, bq[0].addr);
                    chk("wb_data", wb_data, bq[0].data);
                    chk("wb_last", wb_last, bq[0].last);
                    if (wb_ack) begin
                        b = bq.pop_front();
                        cur_beat++;
                        if (b.last) begin
                            void'(mq.pop_front());
                            cur_beat = 0;
                            gap_due  = 1'b1;
                        end
                    end
                end
            end else begin
                chk("wb_last_idle", wb_last, 0);
                if (mq.size() != 0) begin
                    idle_run++;
                    if (idle_run > 2) chk("start_latency", idle_run, 2);
                end
            end
            if (ev_push && ev_dirty && !full_before) begin
                l.tag = ev_tag;
                l.idx = ev_idx;
                mq.push_back(l);
                line_addr = ((64'(ev_tag) << IDX_W) | 64'(ev_idx)) * (LINE_W / 8);
                for (int k = 0; k < BEATS; k++) begin
                    b.addr = ADDR_W'(line_addr + 64'(k * (BEAT_W / 8)));
                    b.data = BEAT_W'(ev_data >> (k * BEAT_W));
                    b.last = (k == BEATS - 1);
                    bq.push_back(b);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_line(input logic [TAG_W-1:0] tag, input logic [IDX_W-1:0] idx, input logic dirty);
        for (int i = 0; i < 50 && ev_full; i++) step();
        if (ev_full) begin
            vectors++;
            miscompares++;
            $display("FAIL push_wait: ev_full stuck at %0d expected 0", ev_full);
        end
        ev_push  = 1'b1;
        ev_dirty = dirty;
        ev_tag   = tag;
        ev_idx   = idx;
        for (int i = 0; i < LINE_W / 32; i++) ev_data[i*32 +: 32] = $urandom;
        step();
        ev_push = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while ((mq.size() != 0 || wb_req) && n < budget) begin
            step();
            n++;
        end
        if (n >= budget) begin
            vectors++;
            miscompares++;
            $display("FAIL drain_timeout: %0d lines left expected 0", mq.size());
        end
    endtask

    task automatic wait_beat(input int beat, input int budget);
        int n;
        n = 0;
        while (!(wb_req && cur_beat == beat) && n < budget) begin
            step();
            n++;
        end
        if (n >= budget) begin
            vectors++;
            miscompares++;
            $display("FAIL beat_timeout: beat %0d expected %0d", cur_beat, beat);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();

        // single dirty line, ack always high
        wb_ack = 1'b1;
        lk_tag = 20'h00ABC;
        lk_idx = 5;
        push_line(20'h00ABC, 5, 1'b1);
        wait_drain(60);
        step();
        chk("t1_empty", empty, 1);

        // clean victim is dropped
        lk_tag = 20'h00123;
        lk_idx = 7;
        push_line(20'h00123, 7, 1'b0);
        repeat (6) step();
        chk("t2_no_req", wb_req, 0);

        // two back-to-back dirty lines fill the buffer; lookup same tag, other idx
        lk_tag = 20'h11111;
        lk_idx = 4;
        push_line(20'h11111, 3, 1'b1);
        push_line(20'h22222, 9, 1'b1);
        chk("t3_full", ev_full, 1);
        wait_drain(80);

        // ack held low on beat 3
        lk_tag = 20'h33333;
        lk_idx = 1;
        push_line(20'h33333, 1, 1'b1);
        wait_beat(3, 40);
        wb_ack = 1'b0;
        repeat (5) step();
        wb_ack = 1'b1;
        wait_drain(60);

        // reset mid-burst at beat 4, then a fresh line from beat 0
        push_line(20'h44444, 2, 1'b1);
        wait_beat(4, 40);
        rst_n = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
        step();
        chk("t5_req_after_rst", wb_req, 0);
        push_line(20'h55555, 2, 1'b1);
        wait_drain(60);

        // randomized traffic over a small tag/idx pool so lookups hit
        for (int c = 0; c < 1500; c++) begin
            ev_push  = !ev_full && ($urandom_range(0, 2) == 0);
            ev_dirty = ($urandom_range(0, 3) != 0);
            ev_tag   = TAG_W'($urandom_range(0, 3));
            ev_idx   = IDX_W'($urandom_range(0, 3));
            for (int i = 0; i < LINE_W / 32; i++) ev_data[i*32 +: 32] = $urandom;
            lk_tag   = TAG_W'($urandom_range(0, 3));
            lk_idx   = IDX_W'($urandom_range(0, 3));
            wb_ack   = ($urandom_range(0, 3) != 0);
            step();
        end
        ev_push = 1'b0;
        wb_ack  = 1'b1;
        wait_drain(100);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
